// File: rtl/psg_pkg.sv
// Shared PSG constants and the envelope-controller FSM state encoding.
package psg_pkg;

   localparam int         PSG_NUM_CH   = 16;
   localparam int         PSG_ATTR_AW  = 6;
   localparam logic [1:0] PSG_BYTE_VOL = 2'd2;
   localparam int         PSG_VOL_W    = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      EMIT = 2'd2
   } psg_env_state_t;

endpackage

// File: rtl/psg_env_step.sv
// One envelope step for a single channel: counts the rate divider and moves
// the volume one unit toward the target when the divider expires.
module psg_env_step
   import psg_pkg::*;
#(
   parameter int RATE_W = 8
) (
   input  logic [PSG_VOL_W-1:0] vol,
   input  logic [PSG_VOL_W-1:0] target,
   input  logic [RATE_W-1:0]    cnt,
   input  logic [RATE_W-1:0]    rate,
   input  logic                 active,
   output logic [PSG_VOL_W-1:0] vol_nxt,
   output logic [RATE_W-1:0]    cnt_nxt,
   output logic                 emit,
   output logic                 done
);

   always_comb begin
      vol_nxt = vol;
      cnt_nxt = cnt;
      done    = active && (vol == target);
      emit    = active && !done && (cnt == rate);
      if (emit) begin
         cnt_nxt = '0;
         // stepping toward the target keeps the volume inside 0..63
         vol_nxt = (vol < target) ? vol + PSG_VOL_W'(1) : vol - PSG_VOL_W'(1);
      end else if (active && !done) begin
         cnt_nxt = cnt + RATE_W'(1);
      end
   end

endmodule

// File: rtl/psg_env_ctrl.sv
// Volume-envelope engine and attribute-port arbiter in front of the PSG.
// Host writes pass straight through; engine writes fill the idle slots.
module psg_env_ctrl
   import psg_pkg::*;
#(
   parameter int NUM_CH = 16,
   parameter int RATE_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [5:0]             cpu_addr,
   input  logic [7:0]             cpu_wrdata,
   input  logic                   cpu_write,
   input  logic [3:0]             env_ch,
   input  logic [5:0]             env_target,
   input  logic [RATE_W-1:0]      env_rate,
   input  logic                   env_start,
   input  logic                   env_stop,
   input  logic                   next_sample,
   output logic [5:0]             attr_addr,
   output logic [7:0]             attr_wrdata,
   output logic                   attr_write,
   output logic                   busy,
   output logic [NUM_CH-1:0]      env_active
);

   localparam int              CH_W    = $clog2(NUM_CH);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   logic [7:0]           shadow [NUM_CH];
   logic [NUM_CH-1:0]    active;
   logic [PSG_VOL_W-1:0] target [NUM_CH];
   logic [RATE_W-1:0]    rate   [NUM_CH];
   logic [RATE_W-1:0]    cnt    [NUM_CH];

   psg_env_state_t  state, state_nxt;
   logic [CH_W-1:0] idx, idx_nxt;
   logic            tick_pend, tick_pend_nxt;
   logic            scan_upd, emit_go;

   logic [CH_W-1:0]      host_ch;
   logic                 host_vol_wr, host_hit, env_hit;
   logic [PSG_VOL_W-1:0] cur_vol, step_vol;
   logic [RATE_W-1:0]    step_cnt;
   logic                 step_emit, step_done;

   assign host_ch     = cpu_addr[5:2];
   assign host_vol_wr = cpu_write && (cpu_addr[1:0] == PSG_BYTE_VOL);
   assign host_hit    = host_vol_wr && (host_ch == idx);
   assign env_hit     = (env_start || env_stop) && (env_ch == idx);
   assign cur_vol     = shadow[idx][PSG_VOL_W-1:0];

   psg_env_step #(.RATE_W(RATE_W)) u_step (
      .vol     (cur_vol),
      .target  (target[idx]),
      .cnt     (cnt[idx]),
      .rate    (rate[idx]),
      .active  (active[idx]),
      .vol_nxt (step_vol),
      .cnt_nxt (step_cnt),
      .emit    (step_emit),
      .done    (step_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         tick_pend <= 1'b0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         tick_pend <= tick_pend_nxt;
      end
   end

   // A host or arming command on the scanned channel overrides the engine
   // for that channel this sample, so the scan simply moves past it.
   always_comb begin
      state_nxt     = state;
      idx_nxt       = idx;
      tick_pend_nxt = tick_pend;
      scan_upd      = 1'b0;
      emit_go       = 1'b0;
      case (state)
         IDLE: begin
            if (next_sample || tick_pend) begin
               tick_pend_nxt = 1'b0;
               idx_nxt       = '0;
               state_nxt     = SCAN;
            end
         end
         SCAN: begin
            if (next_sample) tick_pend_nxt = 1'b1;
            scan_upd = !host_hit && !env_hit;
            if (step_emit && scan_upd) begin
               state_nxt = EMIT;
            end else begin
               idx_nxt = idx + CH_W'(1);
               if (idx == LAST_CH) state_nxt = IDLE;
            end
         end
         EMIT: begin
            if (next_sample) tick_pend_nxt = 1'b1;
            if (host_hit || !cpu_write) begin
               emit_go   = !host_hit;
               idx_nxt   = idx + CH_W'(1);
               state_nxt = (idx == LAST_CH) ? IDLE : SCAN;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         attr_addr   <= '0;
         attr_wrdata <= '0;
         attr_write  <= 1'b0;
         active      <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            shadow[i] <= '0;
            target[i] <= '0;
            rate[i]   <= '0;
            cnt[i]    <= '0;
         end
      end else begin
         attr_write <= 1'b0;
         if (cpu_write) begin
            attr_addr   <= cpu_addr;
            attr_wrdata <= cpu_wrdata;
            attr_write  <= 1'b1;
         end else if (emit_go) begin
            attr_addr   <= {idx, PSG_BYTE_VOL};
            attr_wrdata <= shadow[idx];
            attr_write  <= 1'b1;
         end
         if (scan_upd) begin
            shadow[idx][PSG_VOL_W-1:0] <= step_vol;
            cnt[idx]                   <= step_cnt;
            if (step_done) active[idx] <= 1'b0;
         end
         if (host_vol_wr) begin
            shadow[host_ch] <= cpu_wrdata;
            active[host_ch] <= 1'b0;
         end
         // arming is applied last so a same-cycle start survives the host clear
         if (env_stop) begin
            active[env_ch] <= 1'b0;
         end else if (env_start) begin
            active[env_ch] <= 1'b1;
            target[env_ch] <= env_target;
            rate[env_ch]   <= env_rate;
            cnt[env_ch]    <= '0;
         end
      end
   end

   assign busy       = (state != IDLE) || tick_pend;
   assign env_active = active;

endmodule

// File: tb/tb_psg_env_ctrl.sv
// Directed bench for psg_env_ctrl with a per-sample envelope model and an
// expected-write queue for the engine traffic.
module tb_psg_env_ctrl;
   import psg_pkg::*;

   localparam int RATE_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [5:0]        cpu_addr;
   logic [7:0]        cpu_wrdata;
   logic              cpu_write;
   logic [3:0]        env_ch;
   logic [5:0]        env_target;
   logic [RATE_W-1:0] env_rate;
   logic              env_start, env_stop, next_sample;
   logic [5:0]        attr_addr;
   logic [7:0]        attr_wrdata;
   logic              attr_write, busy;
   logic [15:0]       env_active;

   psg_env_ctrl #(.NUM_CH(16), .RATE_W(RATE_W)) dut (
      .clk(clk), .rst(rst),
      .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata), .cpu_write(cpu_write),
      .env_ch(env_ch), .env_target(env_target), .env_rate(env_rate),
      .env_start(env_start), .env_stop(env_stop), .next_sample(next_sample),
      .attr_addr(attr_addr), .attr_wrdata(attr_wrdata), .attr_write(attr_write),
      .busy(busy), .env_active(env_active)
   );

   always #5 clk = ~clk;

   int          checks = 0, failures = 0, eng_cnt = 0;
   logic [7:0]  last_eng = '0;
   logic [13:0] exp_q[$];
   logic        h_v = 1'b0;
   logic [5:0]  h_a = '0;
   logic [7:0]  h_d = '0;

   logic [7:0]  m_shadow [16];
   bit          m_act    [16];
   int          m_tgt    [16];
   int          m_rate   [16];
   int          m_cnt    [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] m_active_vec();
      logic [15:0] v;
      for (int i = 0; i < 16; i++) v[i] = m_act[i];
      return v;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) begin
         m_shadow[i] = '0; m_act[i] = 0; m_tgt[i] = 0; m_rate[i] = 0; m_cnt[i] = 0;
      end
      exp_q.delete();
   endfunction

   function automatic void model_host(input logic [5:0] a, input logic [7:0] d);
      if (a[1:0] == 2'd2) begin
         m_shadow[a[5:2]] = d;
         m_act[a[5:2]]    = 0;
      end
   endfunction

   function automatic void model_start(input int ch, input int tgt, input int rt);
      m_act[ch] = 1; m_tgt[ch] = tgt; m_rate[ch] = rt; m_cnt[ch] = 0;
   endfunction

   // One audio sample: each armed channel waits rate+1 samples per unit step.
   function automatic void model_tick();
      int v;
      for (int ch = 0; ch < 16; ch++) begin
         if (m_act[ch]) begin
            v = int'(m_shadow[ch][5:0]);
            if (v == m_tgt[ch]) m_act[ch] = 0;
            else if (m_cnt[ch] < m_rate[ch]) m_cnt[ch] = m_cnt[ch] + 1;
            else begin
               m_cnt[ch] = 0;
               v = (v < m_tgt[ch]) ? v + 1 : v - 1;
               m_shadow[ch][5:0] = 6'(v);
               exp_q.push_back({4'(ch), 2'b10, m_shadow[ch]});
            end
         end
      end
   endfunction

   initial forever begin
      @(posedge clk);
      h_v = cpu_write && !rst;
      h_a = cpu_addr;
      h_d = cpu_wrdata;
   end

   // Host writes must echo exactly one cycle later; anything else on the
   // port must be the next expected engine write.
   initial forever begin
      logic [13:0] e;
      @(negedge clk);
      if (!rst) begin
         if (h_v) begin
            checks++;
            if (!(attr_write && attr_addr == h_a && attr_wrdata == h_d)) begin
               failures++;
               $display("FAIL host_passthru actual=%0b/%0h/%0h expected=1/%0h/%0h t=%0t",
                        attr_write, attr_addr, attr_wrdata, h_a, h_d, $time);
            end
         end else if (attr_write) begin
            checks++;
            eng_cnt++;
            last_eng = attr_wrdata;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL engine_write actual=%0h/%0h expected=none t=%0t",
                        attr_addr, attr_wrdata, $time);
            end else begin
               e = exp_q.pop_front();
               if ({attr_addr, attr_wrdata} !== e) begin
                  failures++;
                  $display("FAIL engine_write actual=%0h/%0h expected=%0h/%0h t=%0t",
                           attr_addr, attr_wrdata, e[13:8], e[7:0], $time);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic host_wr(input logic [5:0] a, input logic [7:0] d);
      cpu_addr = a; cpu_wrdata = d; cpu_write = 1'b1;
      step();
      cpu_write = 1'b0;
      model_host(a, d);
   endtask

   task automatic env_go(input int ch, input int tgt, input int rt);
      env_ch = 4'(ch); env_target = 6'(tgt); env_rate = RATE_W'(rt); env_start = 1'b1;
      step();
      env_start = 1'b0;
      model_start(ch, tgt, rt);
   endtask

   task automatic env_halt(input int ch);
      env_ch = 4'(ch); env_stop = 1'b1;
      step();
      env_stop = 1'b0;
      m_act[ch] = 0;
   endtask

   task automatic tick();
      model_tick();
      next_sample = 1'b1;
      step();
      next_sample = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 300) begin step(); n++; end
      if (busy) chk("wait_idle_timeout", busy, 0);
      repeat (2) step();
   endtask

   task automatic drain(input string name);
      chk({name, "_queue"}, exp_q.size(), 0);
      chk({name, "_active"}, env_active, m_active_vec());
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1);
   end

   initial begin
      int c0, nb;
      int exp_w[6] = '{0, 0, 1, 0, 0, 1};
      rst = 1'b1; cpu_addr = '0; cpu_wrdata = '0; cpu_write = 1'b0;
      env_ch = '0; env_target = '0; env_rate = '0;
      env_start = 1'b0; env_stop = 1'b0; next_sample = 1'b0;
      model_reset();
      repeat (3) step();
      chk("rst_attr_addr", attr_addr, 0);
      chk("rst_attr_wrdata", attr_wrdata, 0);
      chk("rst_attr_write", attr_write, 0);
      chk("rst_busy", busy, 0);
      chk("rst_env_active", env_active, 0);
      rst = 1'b0;
      step();

      // host pass-through, then prove shadow[1] holds 0xC5
      host_wr(6'h06, 8'hC5);
      chk("pass_write", attr_write, 1);
      chk("pass_addr", attr_addr, 6'h06);
      chk("pass_data", attr_wrdata, 8'hC5);
      env_go(1, 6, 0);
      tick();
      chk("model_pin_shadow1", exp_q[0], {6'h06, 8'hC6});
      wait_idle();
      chk("shadow1_step", last_eng, 8'hC6);
      tick(); wait_idle();
      drain("pass");

      // ramp up on channel 3
      host_wr(6'h0E, 8'hC0);
      env_go(3, 4, 0);
      for (int i = 0; i < 4; i++) begin
         tick(); wait_idle();
         chk("ramp_up_value", last_eng, 8'hC1 + 8'(i));
      end
      c0 = eng_cnt;
      tick(); wait_idle();
      chk("ramp_up_done_writes", eng_cnt - c0, 0);
      chk("ramp_up_done_active", env_active[3], 0);
      drain("ramp_up");

      // arming in the same cycle as a host volume write
      cpu_addr = 6'h2A; cpu_wrdata = 8'h43; cpu_write = 1'b1;
      env_ch = 4'd10; env_target = 6'd4; env_rate = '0; env_start = 1'b1;
      step();
      cpu_write = 1'b0; env_start = 1'b0;
      model_host(6'h2A, 8'h43);
      model_start(10, 4, 0);
      chk("arm_with_host_active", env_active[10], 1);
      tick(); wait_idle();
      chk("arm_with_host_value", last_eng, 8'h44);
      tick(); wait_idle();
      drain("arm");

      // ramp down with divider on channel 7
      host_wr(6'h1E, 8'h0A);
      env_go(7, 8, 2);
      for (int t = 0; t < 6; t++) begin
         c0 = eng_cnt;
         tick(); wait_idle();
         chk("ramp_dn_writes", eng_cnt - c0, exp_w[t]);
      end
      chk("ramp_dn_final", last_eng, 8'h08);
      tick(); wait_idle();
      drain("ramp_dn");

      // host write to another channel collides with the ch2 EMIT
      host_wr(6'h0A, 8'h80);
      env_go(2, 5, 0);
      tick();
      repeat (3) step();
      cpu_addr = 6'h14; cpu_wrdata = 8'h5A; cpu_write = 1'b1;
      step();
      cpu_write = 1'b0;
      chk("arb_host_first", attr_addr, 6'h14);
      step();
      chk("arb_emit_write", attr_write, 1);
      chk("arb_emit_addr", attr_addr, 6'h0A);
      chk("arb_emit_data", attr_wrdata, 8'h81);
      wait_idle();
      drain("arb");

      // host volume write to the stalled channel drops the EMIT
      tick();
      chk("model_pin_arb", exp_q[0], {6'h0A, 8'h82});
      void'(exp_q.pop_back());
      repeat (3) step();
      cpu_addr = 6'h0A; cpu_wrdata = 8'h33; cpu_write = 1'b1;
      step();
      cpu_write = 1'b0;
      model_host(6'h0A, 8'h33);
      chk("drop_host_data", attr_wrdata, 8'h33);
      step();
      chk("drop_no_emit", attr_write, 0);
      wait_idle();
      chk("drop_active", env_active[2], 0);
      drain("drop");

      // three ticks inside one scan queue exactly one more scan
      host_wr(6'h12, 8'h00);
      env_go(4, 10, 0);
      model_tick(); model_tick();
      c0 = eng_cnt;
      next_sample = 1'b1;
      step();
      nb = busy ? 1 : 0;
      for (int s = 1; s < 200; s++) begin
         next_sample = (s == 2 || s == 4 || s == 6);
         step();
         if (!busy) break;
         nb++;
      end
      next_sample = 1'b0;
      repeat (2) step();
      chk("overlap_busy_cycles", nb, 35);
      chk("overlap_writes", eng_cnt - c0, 2);
      env_halt(4);
      drain("overlap");

      // reset while the engine sits in EMIT for channel 9
      host_wr(6'h26, 8'hC0);
      env_go(9, 3, 0);
      tick();
      repeat (10) step();
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_attr_addr", attr_addr, 0);
      chk("mid_rst_attr_wrdata", attr_wrdata, 0);
      chk("mid_rst_attr_write", attr_write, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_env_active", env_active, 0);
      model_reset();
      step(); step();
      rst = 1'b0;
      c0 = eng_cnt;
      repeat (40) step();
      chk("post_rst_writes", eng_cnt - c0, 0);
      drain("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
